// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory Wishbone master.
// Access sizes, FSM states and the natural-alignment check.
package dmem_pkg;

   typedef enum logic [1:0] {
      SZ_B,
      SZ_H,
      SZ_W,
      SZ_D
   } dmem_size_e;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      DONE
   } dmem_state_e;

   function automatic logic is_aligned(
      input logic [2:0] addr,
      input dmem_size_e size
   );
      logic [2:0] m;
      m = 3'((4'd1 << size) - 4'd1);
      return (addr & m) == 3'd0;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for stores and
// extraction plus sign/zero extension for loads.
module dmem_lane_align
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic [$clog2(DATA_WIDTH/8)-1:0] lane_i,
   input  dmem_size_e                      size_i,
   input  logic                            unsigned_i,
   input  logic [DATA_WIDTH-1:0]           wdata_i,
   input  logic [DATA_WIDTH-1:0]           bus_i,
   output logic [DATA_WIDTH-1:0]           dat_o,
   output logic [DATA_WIDTH/8-1:0]         sel_o,
   output logic [DATA_WIDTH-1:0]           rdata_o
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int IW = $clog2(DATA_WIDTH);

   logic [7:0]            mask8;
   logic [6:0]            nbits;
   logic [IW-1:0]         msb;
   logic [DATA_WIDTH-1:0] sh;
   logic [DATA_WIDTH-1:0] keep;
   logic                  neg;

   always_comb begin
      mask8 = 8'h00;
      case (size_i)
         SZ_B: mask8 = 8'h01;
         SZ_H: mask8 = 8'h03;
         SZ_W: mask8 = 8'h0F;
         SZ_D: mask8 = 8'hFF;
         default: mask8 = 8'h00;
      endcase
   end

   assign dat_o = wdata_i << {lane_i, 3'b000};
   assign sel_o = mask8[NB-1:0] << lane_i;

   // A shift of DATA_WIDTH or more clears everything, so full-width
   // loads get keep = all ones and pass through untouched.
   assign sh      = bus_i >> {lane_i, 3'b000};
   assign nbits   = 7'd8 << size_i;
   assign msb     = IW'(nbits - 7'd1);
   assign keep    = ~({DATA_WIDTH{1'b1}} << nbits);
   assign neg     = ~unsigned_i & sh[msb];
   assign rdata_o = (sh & keep) | (neg ? ~keep : '0);

endmodule

// File: rtl/dmem_wb_master.sv
// Wishbone B4 classic data-memory master for the MEM stage.
// Optional bus watchdog enabled by defining DMEM_WB_TIMEOUT_EN.
module dmem_wb_master
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    req_valid_i,
   input  logic                    req_we_i,
   input  logic [1:0]              req_size_i,
   input  logic                    req_unsigned_i,
   input  logic [ADDR_WIDTH-1:0]   req_addr_i,
   input  logic [DATA_WIDTH-1:0]   req_wdata_i,
   output logic                    rsp_valid_o,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    misalign_o,
   output logic                    bus_err_o,
   output logic                    stall_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int LW = $clog2(NB);

   dmem_state_e           state_q;
   logic                  cyc_q;
   logic                  we_q;
   logic [ADDR_WIDTH-1:0] adr_q;
   logic [DATA_WIDTH-1:0] dat_q;
   logic [NB-1:0]         sel_q;
   logic                  rsp_q;
   logic                  mis_q;
   logic                  err_q;
   logic [DATA_WIDTH-1:0] rdata_q;

   dmem_size_e            size;
   logic                  legal;
   logic [DATA_WIDTH-1:0] st_dat;
   logic [NB-1:0]         st_sel;
   logic [DATA_WIDTH-1:0] ld_data;

`ifdef DMEM_WB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] cnt_q;
`endif

   assign size  = dmem_size_e'(req_size_i);
   assign legal = is_aligned(req_addr_i[2:0], size)
                  && (size != SZ_D || DATA_WIDTH == 64);

   dmem_lane_align #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_align (
      .lane_i    (req_addr_i[LW-1:0]),
      .size_i    (size),
      .unsigned_i(req_unsigned_i),
      .wdata_i   (req_wdata_i),
      .bus_i     (wb_dat_i),
      .dat_o     (st_dat),
      .sel_o     (st_sel),
      .rdata_o   (ld_data)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cyc_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= '0;
         dat_q   <= '0;
         sel_q   <= '0;
         rsp_q   <= 1'b0;
         mis_q   <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
`ifdef DMEM_WB_TIMEOUT_EN
         cnt_q   <= '0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid_i && legal) begin
                  state_q <= BUS;
                  cyc_q   <= 1'b1;
                  we_q    <= req_we_i;
                  adr_q   <= {req_addr_i[ADDR_WIDTH-1:LW], {LW{1'b0}}};
                  dat_q   <= st_dat;
                  sel_q   <= st_sel;
`ifdef DMEM_WB_TIMEOUT_EN
                  cnt_q   <= '0;
`endif
               end else if (req_valid_i) begin
                  state_q <= DONE;
                  rsp_q   <= 1'b1;
                  mis_q   <= 1'b1;
               end
            end
            BUS: begin
               // err has priority over a simultaneous ack
               if (wb_err_i || wb_ack_i) begin
                  state_q <= DONE;
                  cyc_q   <= 1'b0;
                  we_q    <= 1'b0;
                  adr_q   <= '0;
                  dat_q   <= '0;
                  sel_q   <= '0;
                  rsp_q   <= 1'b1;
                  err_q   <= wb_err_i;
                  rdata_q <= (wb_err_i || we_q) ? '0 : ld_data;
               end
`ifdef DMEM_WB_TIMEOUT_EN
               else if (cnt_q + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
                  state_q <= DONE;
                  cyc_q   <= 1'b0;
                  we_q    <= 1'b0;
                  adr_q   <= '0;
                  dat_q   <= '0;
                  sel_q   <= '0;
                  rsp_q   <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
`endif
            end
            DONE: begin
               state_q <= IDLE;
               rsp_q   <= 1'b0;
               mis_q   <= 1'b0;
               err_q   <= 1'b0;
               rdata_q <= '0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rsp_valid_o = rsp_q;
   assign rsp_rdata_o = rdata_q;
   assign misalign_o  = mis_q;
   assign bus_err_o   = err_q;
   assign stall_o     = req_valid_i & ~rsp_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = cyc_q;
   assign wb_we_o     = we_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
   assign wb_sel_o    = sel_q;

endmodule

// File: tb/tb_dmem_wb_master.sv
// Scoreboard bench for dmem_wb_master (32-bit bus) with a
// byte-level reference model and a randomised Wishbone slave.
module tb_dmem_wb_master;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_valid_i = 1'b0;
   logic        req_we_i = 1'b0;
   logic [1:0]  req_size_i = 2'd0;
   logic        req_unsigned_i = 1'b0;
   logic [31:0] req_addr_i = '0;
   logic [31:0] req_wdata_i = '0;
   logic        rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        misalign_o;
   logic        bus_err_o;
   logic        stall_o;
   logic        wb_cyc_o;
   logic        wb_stb_o;
   logic        wb_we_o;
   logic [31:0] wb_adr_o;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_o;
   logic [31:0] wb_dat_i = '0;
   logic        wb_ack_i = 1'b0;
   logic        wb_err_i = 1'b0;

   dmem_wb_master #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_we_i(req_we_i),
      .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .misalign_o(misalign_o), .bus_err_o(bus_err_o),
      .stall_o(stall_o),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
      .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      logic        err;
   } exp_t;

   exp_t expq[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic m_legal(input logic [31:0] a, input logic [1:0] sz);
      int nb;
      nb = 1 << sz;
      return (a % nb) == 0 && sz != 2'd3;
   endfunction

   function automatic logic [3:0] m_sel(input logic [31:0] a, input logic [1:0] sz);
      logic [3:0] s;
      int ln;
      s  = '0;
      ln = int'(a[1:0]);
      for (int i = 0; i < (1 << sz); i++) s[ln+i] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] m_dat(input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] d;
      int ln;
      d  = '0;
      ln = int'(a[1:0]);
      for (int j = ln; j < 4; j++) d[8*j +: 8] = wd[8*(j-ln) +: 8];
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] bus, input logic [31:0] a,
                                          input logic [1:0] sz, input logic uns);
      logic [31:0] v;
      int nb, ln;
      v  = '0;
      nb = 1 << sz;
      ln = int'(a[1:0]);
      for (int i = 0; i < nb; i++) v[8*i +: 8] = bus[8*(ln+i) +: 8];
      if (!uns && v[8*nb-1])
         for (int b = 8 * nb; b < 32; b++) v[b] = 1'b1;
      return v;
   endfunction

   // monitor: pops one expectation per response pulse
   always @(negedge clk_i) begin
      if (!rst_i && rsp_valid_o) begin
         if (expq.size() == 0) begin
            chk("unexpected_rsp", 1, 0);
         end else begin
            exp_t e;
            e = expq.pop_front();
            chk("rsp_rdata", rsp_rdata_o, e.rdata);
            chk("rsp_misalign", misalign_o, e.mis);
            chk("rsp_bus_err", bus_err_o, e.err);
         end
      end
   end

   // mode 0: ack after wt cycles, 1: err (maybe with ack), 2: silent slave
   task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] bus, input int wt, input int mode);
      exp_t e;
      logic legal;
      int   lat, stl, cycn;
      bit   done;
      legal   = m_legal(a, sz);
      e.mis   = !legal;
      e.err   = legal && mode != 0;
      e.rdata = (legal && mode == 0 && !we) ? m_load(bus, a, sz, uns) : '0;
      @(posedge clk_i);
      #1;
      req_valid_i    = 1'b1;
      req_we_i       = we;
      req_size_i     = sz;
      req_unsigned_i = uns;
      req_addr_i     = a;
      req_wdata_i    = wd;
      wb_dat_i       = bus;
      expq.push_back(e);
      lat  = 0;
      stl  = 0;
      cycn = 0;
      done = 0;
      while (!done && lat < 400) begin
         @(negedge clk_i);
         lat++;
         if (stall_o) stl++;
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         if (wb_cyc_o) begin
            if (cycn == 0) begin
               chk("wb_stb", wb_stb_o, 1);
               chk("wb_we", wb_we_o, we);
               chk("wb_adr", wb_adr_o, {a[31:2], 2'b00});
               chk("wb_sel", wb_sel_o, m_sel(a, sz));
               if (we) chk("wb_dat", wb_dat_o, m_dat(a, wd));
            end
            cycn++;
            if (cycn > wt) begin
               if (mode == 0) begin
                  wb_ack_i = 1'b1;
               end else if (mode == 1) begin
                  wb_err_i = 1'b1;
                  wb_ack_i = 1'($urandom_range(1));
               end
            end
         end
         if (rsp_valid_o) done = 1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL rsp_timeout act=none exp=rsp_valid t=%0t", $time);
         expq.delete();
         wb_ack_i = 1'b0;
         wb_err_i = 1'b0;
         rst_i    = 1'b1;
         @(posedge clk_i);
         #1 rst_i = 1'b0;
      end else if (!legal) begin
         chk("mis_latency", lat, 2);
         chk("mis_no_cyc", cycn, 0);
         chk("mis_stall", stl, 1);
      end else if (mode == 2) begin
         chk("to_cyc_len", cycn, 4);
         chk("to_latency", lat, 6);
      end else begin
         chk("latency", lat, wt + 3);
         chk("cyc_len", cycn, wt + 1);
         chk("stall_len", stl, lat - 1);
      end
      @(posedge clk_i);
      #1 req_valid_i = 1'b0;
      @(negedge clk_i);
      chk("rsp_one_cycle", rsp_valid_o, 0);
      chk("no_reissue", wb_cyc_o, 0);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk_i);
      chk("rst_rsp", rsp_valid_o, 0);
      chk("rst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
      chk("rst_bus", {wb_adr_o, wb_dat_o}, 0);
      chk("rst_misc", {misalign_o, bus_err_o, wb_sel_o, rsp_rdata_o}, 0);
      @(posedge clk_i);
      #1 rst_i = 1'b0;

      issue(1, 2'd0, 0, 32'h1003, 32'h0000_00AB, 32'h0, 0, 0);
      issue(0, 2'd0, 0, 32'h1001, 32'h0, 32'h0000_8000, 0, 0);
      issue(0, 2'd0, 1, 32'h1001, 32'h0, 32'h0000_8000, 1, 0);
      issue(0, 2'd1, 0, 32'h1002, 32'h0, 32'h8001_0000, 2, 0);
      issue(0, 2'd2, 0, 32'h1002, 32'h0, 32'h1234_5678, 0, 0);
      issue(0, 2'd3, 0, 32'h2008, 32'h0, 32'h1234_5678, 0, 0);
      issue(0, 2'd2, 0, 32'h4000, 32'h0, 32'hDEAD_BEEF, 1, 1);
      issue(1, 2'd2, 0, 32'h4004, 32'hCAFE_F00D, 32'h0, 3, 0);

      // reset in the middle of a bus cycle
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b1;
      req_we_i    = 1'b0;
      req_size_i  = 2'd2;
      req_addr_i  = 32'h5000;
      n = 0;
      while (!wb_cyc_o && n < 10) begin
         @(negedge clk_i);
         n++;
      end
      chk("rst_mid_cyc_seen", wb_cyc_o, 1);
      rst_i = 1'b1;
      #1;
      chk("rst_mid_cyc_drop", {wb_cyc_o, wb_stb_o}, 0);
      @(posedge clk_i);
      #1;
      req_valid_i = 1'b0;
      rst_i       = 1'b0;
      n = 0;
      repeat (3) begin
         @(negedge clk_i);
         if (rsp_valid_o) n++;
      end
      chk("rst_mid_no_rsp", n, 0);
      issue(0, 2'd1, 1, 32'h5006, 32'h0, 32'hF00D_0000, 0, 0);

`ifdef DMEM_WB_TIMEOUT_EN
      issue(0, 2'd2, 0, 32'h3000, 32'h0, 32'h1111_2222, 0, 2);
      issue(1, 2'd0, 0, 32'h3001, 32'h77, 32'h0, 0, 0);
`endif

      for (int k = 0; k < 200; k++) begin
         logic [31:0] a;
         logic [1:0]  sz;
         sz = 2'($urandom_range(3));
         a  = $urandom;
         if ($urandom_range(1) == 1) a[1:0] = a[1:0] & ~2'(((1 << sz) - 1));
         issue(1'($urandom_range(1)), sz, 1'($urandom_range(1)), a,
               $urandom, $urandom, int'($urandom_range(3)),
               ($urandom_range(7) == 0) ? 1 : 0);
      end

      repeat (2) @(negedge clk_i);
      chk("queue_drained", expq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
